// File: rtl/input_tile_sched_if.sv
// Handshake and address bundle between the input-tile scheduler and its
// neighbours (control host, input buffer, datapath).
interface input_tile_sched_if #(
    parameter int AW = 32
);
    logic          start;
    logic          abort;
    logic [AW-1:0] base_addr;
    logic          blkend;
    logic          result_valid;
    logic          init_addr_en;
    logic [AW-1:0] init_addr;
    logic          data_load;
    logic          busy;
    logic          mapend;
    logic [15:0]   tile_x;
    logic [15:0]   tile_y;
    logic          err;

    modport master (
        output start, abort, base_addr, blkend, result_valid,
        input  init_addr_en, init_addr, data_load, busy, mapend, tile_x, tile_y, err
    );

    modport slave (
        input  start, abort, base_addr, blkend, result_valid,
        output init_addr_en, init_addr, data_load, busy, mapend, tile_x, tile_y, err
    );
endinterface

// File: rtl/input_tile_sched.sv
// Walks a feature map tile by tile, issuing start addresses to the input buffer.
// Optional watchdog on LOAD/COMPUTE waits: define INPUT_TILE_SCHED_TIMEOUT_EN.
module input_tile_sched #(
    parameter int AW      = 32,
    parameter int IW      = 224,
    parameter int IH      = 224,
    parameter int POX     = 15,
    parameter int POY     = 3,
    parameter int STRIDE  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input_tile_sched_if.slave     bus
);
    localparam int XSTEP = POX * STRIDE;
    localparam int YROWS = POY * STRIDE;
    localparam int YSTEP = YROWS * IW;
    localparam int NTX   = (IW + XSTEP - 1) / XSTEP;
    localparam int NTY   = (IH + YROWS - 1) / YROWS;

    localparam logic [15:0]   LAST_X  = 16'(NTX - 1);
    localparam logic [15:0]   LAST_Y  = 16'(NTY - 1);
    localparam logic [AW-1:0] XSTEP_A = AW'(XSTEP);
    localparam logic [AW-1:0] YSTEP_A = AW'(YSTEP);

    if (TIMEOUT < 2) begin : g_timeout_check
        $error("input_tile_sched: TIMEOUT must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        LOAD,
        COMPUTE,
        NEXT,
        DONE
    } state_t;

    state_t        state, state_next;
    logic [AW-1:0] init_addr_q, row_base_q;
    logic [15:0]   tile_x_q, tile_y_q;
    logic          start_ok;
    logic          last_tile;
    logic          wd_fire;
    logic          in_wait;

    assign start_ok  = (state == IDLE) && bus.start && !bus.abort;
    assign last_tile = (tile_x_q == LAST_X) && (tile_y_q == LAST_Y);
    assign in_wait   = (state == LOAD) || (state == COMPUTE);

`ifdef INPUT_TILE_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_cnt_q;
    logic          err_q;

    assign wd_fire = in_wait && (wd_cnt_q == CW'(TIMEOUT - 1));

    // Counter restarts whenever a wait state is freshly entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if ((state_next == LOAD || state_next == COMPUTE) && state_next != state)
                wd_cnt_q <= '0;
            else if (in_wait)
                wd_cnt_q <= wd_cnt_q + 1'b1;

            if (start_ok)
                err_q <= 1'b0;
            else if (wd_fire && !bus.abort)
                err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign wd_fire = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // abort outranks everything, then the watchdog, then normal sequencing.
    always_comb begin
        state_next = state;
        if (bus.abort) begin
            state_next = IDLE;
        end else if (wd_fire) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.start) state_next = ISSUE;
                ISSUE:   state_next = bus.blkend ? COMPUTE : LOAD;
                LOAD:    if (bus.blkend) state_next = COMPUTE;
                COMPUTE: if (bus.result_valid) state_next = last_tile ? DONE : NEXT;
                NEXT:    state_next = ISSUE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Row wrap restarts from the tracked row base, never from the running address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_addr_q <= '0;
            row_base_q  <= '0;
            tile_x_q    <= '0;
            tile_y_q    <= '0;
        end else if (start_ok) begin
            init_addr_q <= bus.base_addr;
            row_base_q  <= bus.base_addr;
            tile_x_q    <= '0;
            tile_y_q    <= '0;
        end else if (state == NEXT && !bus.abort) begin
            if (tile_x_q != LAST_X) begin
                tile_x_q    <= tile_x_q + 16'd1;
                init_addr_q <= init_addr_q + XSTEP_A;
            end else begin
                tile_x_q    <= '0;
                tile_y_q    <= tile_y_q + 16'd1;
                init_addr_q <= row_base_q + YSTEP_A;
                row_base_q  <= row_base_q + YSTEP_A;
            end
        end
    end

    assign bus.init_addr_en = (state == ISSUE);
    assign bus.data_load    = (state == ISSUE) || (state == LOAD);
    assign bus.busy         = (state != IDLE);
    assign bus.mapend       = (state == DONE);
    assign bus.init_addr    = init_addr_q;
    assign bus.tile_x       = tile_x_q;
    assign bus.tile_y       = tile_y_q;
endmodule

// File: tb/tb_input_tile_sched.sv
// Randomised directed bench for input_tile_sched against a closed-form tile/address model.
module tb_input_tile_sched;
    localparam int AW     = 32;
    localparam int IW     = 224;
    localparam int IH     = 224;
    localparam int POX    = 15;
    localparam int POY    = 3;
    localparam int STRIDE = 2;
`ifdef INPUT_TILE_SCHED_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif
    localparam int NTX    = (IW + POX * STRIDE - 1) / (POX * STRIDE);
    localparam int NTY    = (IH + POY * STRIDE - 1) / (POY * STRIDE);
    localparam int NTILES = NTX * NTY;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    input_tile_sched_if #(.AW(AW)) bus ();

    input_tile_sched #(
        .AW(AW), .IW(IW), .IH(IH), .POX(POX), .POY(POY), .STRIDE(STRIDE), .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int en_count    = 0;
    int map_count   = 0;

    always @(negedge clk) begin
        en_count  <= en_count + int'(bus.init_addr_en);
        map_count <= map_count + int'(bus.mapend);
        vectors++;
        if (bus.init_addr_en === 1'b1 && bus.data_load !== 1'b1) begin
            miscompares++;
            $error("FAIL mon_en_implies_dl");
        end
        if (bus.data_load === 1'b1 && bus.busy !== 1'b1) begin
            miscompares++;
            $error("FAIL mon_dl_implies_busy");
        end
        if (bus.mapend === 1'b1 && bus.busy !== 1'b1) begin
            miscompares++;
            $error("FAIL mon_mapend_implies_busy");
        end
        if (rst === 1'b1 && bus.busy !== 1'b0) begin
            miscompares++;
            $error("FAIL mon_rst_busy");
        end
`ifndef INPUT_TILE_SCHED_TIMEOUT_EN
        if (bus.err !== 1'b0) begin
            miscompares++;
            $error("FAIL mon_err_const");
        end
`endif
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    `define CHK(tag, o, e) check(tag, 64'(o), 64'(e))

    // Tile k of a pass is (k mod NTX, k div NTX); its address follows directly.
    function automatic logic [31:0] exp_addr(input logic [31:0] base, input int k);
        return base + 32'((k / NTX) * (POY * STRIDE * IW)) + 32'((k % NTX) * (POX * STRIDE));
    endfunction

    task automatic check_all_zero(input string tag);
        `CHK({tag, "_en"},    bus.init_addr_en, 0);
        `CHK({tag, "_dl"},    bus.data_load, 0);
        `CHK({tag, "_busy"},  bus.busy, 0);
        `CHK({tag, "_mapend"}, bus.mapend, 0);
        `CHK({tag, "_err"},   bus.err, 0);
        `CHK({tag, "_addr"},  bus.init_addr, 0);
        `CHK({tag, "_tx"},    bus.tile_x, 0);
        `CHK({tag, "_ty"},    bus.tile_y, 0);
    endtask

    task automatic start_pass(input logic [31:0] base);
        bus.base_addr = base;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.base_addr = $urandom;
    endtask

    // Entered at the negedge of ISSUE. mode 0: normal, 1: abort in LOAD, 2: reset in COMPUTE.
    task automatic run_tile(input logic [31:0] base, input int k, input int mode);
        int d;
        int r;
        `CHK("issue_en", bus.init_addr_en, 1);
        `CHK("issue_dl", bus.data_load, 1);
        `CHK("issue_busy", bus.busy, 1);
        `CHK("issue_addr", bus.init_addr, exp_addr(base, k));
        `CHK("issue_tx", bus.tile_x, k % NTX);
        `CHK("issue_ty", bus.tile_y, k / NTX);
        d = (mode != 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
        bus.blkend       = (d == 0);
        bus.result_valid = 1'($urandom_range(0, 1));
        for (int i = 1; i <= d; i++) begin
            @(negedge clk);
            `CHK("load_dl", bus.data_load, 1);
            `CHK("load_en", bus.init_addr_en, 0);
            if (mode == 1 && i == 1) begin
                bus.abort        = 1'b1;
                bus.start        = 1'b1;
                bus.blkend       = 1'b0;
                bus.result_valid = 1'b0;
                @(negedge clk);
                bus.abort = 1'b0;
                bus.start = 1'b0;
                `CHK("abort_dl", bus.data_load, 0);
                `CHK("abort_busy", bus.busy, 0);
                `CHK("abort_mapend", bus.mapend, 0);
                @(negedge clk);
                `CHK("abort_idle_busy", bus.busy, 0);
                return;
            end
            bus.blkend       = (i == d);
            bus.result_valid = 1'($urandom_range(0, 1));
            bus.start        = 1'($urandom_range(0, 1));
            bus.base_addr    = $urandom;
        end
        @(negedge clk);
        bus.blkend       = 1'b0;
        bus.result_valid = 1'b0;
        bus.start        = 1'b0;
        `CHK("cmp_dl", bus.data_load, 0);
        `CHK("cmp_busy", bus.busy, 1);
        `CHK("cmp_en", bus.init_addr_en, 0);
        if (mode == 2) begin
            #2 rst = 1'b1;
            #1 check_all_zero("rst_mid");
            @(negedge clk);
            rst = 1'b0;
            return;
        end
        r = int'($urandom_range(0, 3));
        for (int i = 0; i < r; i++) begin
            bus.start     = 1'($urandom_range(0, 1));
            bus.base_addr = $urandom;
            bus.blkend    = 1'($urandom_range(0, 1));
            @(negedge clk);
            `CHK("wait_dl", bus.data_load, 0);
            `CHK("wait_busy", bus.busy, 1);
        end
        bus.start        = 1'b0;
        bus.blkend       = 1'b0;
        bus.result_valid = 1'b1;
        @(negedge clk);
        bus.result_valid = 1'b0;
        if (k == NTILES - 1) begin
            `CHK("done_mapend", bus.mapend, 1);
            `CHK("done_busy", bus.busy, 1);
            @(negedge clk);
            `CHK("idle_mapend", bus.mapend, 0);
            `CHK("idle_busy", bus.busy, 0);
        end else begin
            `CHK("next_mapend", bus.mapend, 0);
            `CHK("next_dl", bus.data_load, 0);
            @(negedge clk);
        end
    endtask

    task automatic full_pass(input logic [31:0] base, input string tag);
        int e0;
        int m0;
        e0 = en_count;
        m0 = map_count;
        start_pass(base);
        for (int k = 0; k < NTILES; k++) begin
            if (base == 32'h0000_000A) begin
                if (k == 0)          `CHK("addr_0_0", bus.init_addr, 32'h0A);
                if (k == 1)          `CHK("addr_1_0", bus.init_addr, 32'h28);
                if (k == NTX)        `CHK("addr_0_1", bus.init_addr, 32'h54A);
                if (k == NTILES - 1) `CHK("addr_last", bus.init_addr, 32'hC31C);
            end
            run_tile(base, k, 0);
        end
        @(negedge clk);
        `CHK({tag, "_en_pulses"}, en_count - e0, 304);
        `CHK({tag, "_mapends"}, map_count - m0, 1);
    endtask

    initial begin
        logic [31:0] b;
        int m0;
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.base_addr    = '0;
        bus.blkend       = 1'b0;
        bus.result_valid = 1'b0;

        #3 check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        // abort beats start while idle; stray handshakes are ignored in IDLE
        bus.abort     = 1'b1;
        bus.start     = 1'b1;
        bus.base_addr = 32'h1234_5678;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        `CHK("abort_over_start_busy", bus.busy, 0);
        `CHK("abort_over_start_en", bus.init_addr_en, 0);
        bus.blkend       = 1'b1;
        bus.result_valid = 1'b1;
        @(negedge clk);
        bus.blkend       = 1'b0;
        bus.result_valid = 1'b0;
        `CHK("idle_ignore_busy", bus.busy, 0);

        full_pass(32'h0000_000A, "pass_a");

        b = 32'hFFFF_0000 | 32'($urandom_range(0, 65535));
        full_pass(b, "pass_wrap");

        // abort during LOAD of tile (3,2)
        m0 = map_count;
        b  = $urandom;
        start_pass(b);
        for (int k = 0; k < 2 * NTX + 3; k++) run_tile(b, k, 0);
        run_tile(b, 2 * NTX + 3, 1);
        @(negedge clk);
        `CHK("abort_no_mapend", map_count - m0, 0);

        // reset mid-COMPUTE, then restart from a fresh base
        b = $urandom;
        start_pass(b);
        for (int k = 0; k < 5; k++) run_tile(b, k, 0);
        run_tile(b, 5, 2);
        check_all_zero("after_rst");
        b = $urandom;
        start_pass(b);
        for (int k = 0; k < 3; k++) run_tile(b, k, 0);
        run_tile(b, 3, 1);

        // blkend withheld
        b = $urandom;
        start_pass(b);
        `CHK("wd_issue_en", bus.init_addr_en, 1);
`ifdef INPUT_TILE_SCHED_TIMEOUT_EN
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            `CHK("wd_load_dl", bus.data_load, 1);
            `CHK("wd_load_err", bus.err, 0);
        end
        @(negedge clk);
        `CHK("wd_err", bus.err, 1);
        `CHK("wd_busy", bus.busy, 0);
        start_pass(b);
        `CHK("wd_err_cleared", bus.err, 0);
        `CHK("wd_restart_addr", bus.init_addr, b);
`else
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            `CHK("hold_load_dl", bus.data_load, 1);
            `CHK("hold_load_busy", bus.busy, 1);
            `CHK("hold_load_err", bus.err, 0);
        end
`endif
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        `CHK("final_busy", bus.busy, 0);
        `CHK("final_dl", bus.data_load, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
